// File: rtl/main_memory_responder_pkg.sv
// Shared cache/DRAM configuration: bus geometry, DRAM latencies and the
// types used by the main-memory responder.
package CacheConfig;

  localparam int addressBusWidth    = 16;
  localparam int wordSize           = 32;
  localparam int pageSize           = 2;
  localparam int DRAM_read_latency  = 4;
  localparam int DRAM_write_latency = 6;

  localparam int LINE_W      = pageSize * wordSize;
  localparam int LINE_ADDR_W = addressBusWidth - 3;
  localparam int LAT_W       = 4;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    STROBE,
    RECOVER
  } mem_state_t;

endpackage

// File: rtl/main_memory_responder_tick_gen.sv
// DRAM clock prescaler: counts 0..DIV-1 and flags the cycle before it wraps,
// so the counter update on that edge is one DRAM tick.
module dram_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_L,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || (cnt_q == CNT_W'(DIV - 1))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_W'(DIV - 1)) && !restart_i;

endmodule

// File: rtl/main_memory_responder.sv
// Synthesizable DRAM model answering the cache's line-fill and write-back
// request levels with a full line and a completion strobe after a fixed latency.
module main_memory_responder
  import CacheConfig::*;
#(
  parameter int MEM_LINES     = 64,
  parameter int DRAM_CLK_DIV  = 10,
  parameter int STROBE_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   fetchReq,
  input  logic                   writebackReq,
  input  logic [LINE_ADDR_W-1:0] lineAddress,
  input  logic [LINE_W-1:0]      lineDataIn,
  output logic [LINE_W-1:0]      lineDataOut,
  output logic                   busDrive,
  output logic                   dataStrobe,
  output logic                   busy
);

  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int STB_W = $clog2(STROBE_CYCLES + 1);

  mem_state_t       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [STB_W-1:0] strb_q, strb_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  line_t            data_q, data_d;
  line_t            lineDataOut_q;
  logic             busDrive_q, busDrive_d;
  logic             restart;
  logic             tick;
  logic             commitWrite;
  logic             loadRead;

  line_t store [MEM_LINES];

  // Upper address bits alias onto the same entry, so they are deliberately dropped.
  logic unusedAddrBits;
  assign unusedAddrBits = ^lineAddress[LINE_ADDR_W-1:IDX_W];

  dram_tick_gen #(
    .DIV (DRAM_CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset_L   (reset_L),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    strb_d      = strb_q;
    addr_d      = addr_q;
    data_d      = data_q;
    busDrive_d  = busDrive_q;
    restart     = 1'b0;
    commitWrite = 1'b0;
    loadRead    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (writebackReq) begin
          state_d = WRITE_WAIT;
          addr_d  = lineAddress[IDX_W-1:0];
          data_d  = lineDataIn;
          lat_d   = LAT_W'(DRAM_write_latency);
          restart = 1'b1;
        end else if (fetchReq) begin
          state_d = READ_WAIT;
          addr_d  = lineAddress[IDX_W-1:0];
          lat_d   = LAT_W'(DRAM_read_latency);
          restart = 1'b1;
        end
      end
      READ_WAIT, WRITE_WAIT: begin
        // The final tick both empties the counter and completes the access.
        if (tick) begin
          if (lat_q <= LAT_W'(1)) begin
            lat_d   = '0;
            state_d = STROBE;
            strb_d  = STB_W'(STROBE_CYCLES - 1);
            if (state_q == READ_WAIT) begin
              loadRead   = 1'b1;
              busDrive_d = 1'b1;
            end else begin
              commitWrite = 1'b1;
            end
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
      end
      STROBE: begin
        if (strb_q == '0) begin
          state_d = RECOVER;
        end else begin
          strb_d = strb_q - STB_W'(1);
        end
      end
      RECOVER: begin
        if (!fetchReq && !writebackReq) begin
          state_d    = IDLE;
          busDrive_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        busDrive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      strb_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      busDrive_q    <= 1'b0;
      lineDataOut_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      strb_q     <= strb_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busDrive_q <= busDrive_d;
      if (loadRead) begin
        lineDataOut_q <= store[addr_q];
      end
    end
  end

  // Backing store keeps its contents across reset; a reset edge cancels the commit.
  always_ff @(posedge clk) begin
    if (reset_L && commitWrite) begin
      store[addr_q] <= data_q;
    end
  end

  assign lineDataOut = lineDataOut_q;
  assign busDrive    = busDrive_q;
  assign dataStrobe  = (state_q == STROBE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed self-checking bench for main_memory_responder: latency, data path,
// request priority, held levels, reset abort and index aliasing.
module tb_main_memory_responder;
  import CacheConfig::*;

  localparam int DIV = 10;
  localparam int STB = 5;
  localparam int RD_LAT = DRAM_read_latency * DIV;
  localparam int WR_LAT = DRAM_write_latency * DIV;

  logic                   clk;
  logic                   reset_L;
  logic                   fetchReq;
  logic                   writebackReq;
  logic [LINE_ADDR_W-1:0] lineAddress;
  logic [LINE_W-1:0]      lineDataIn;
  logic [LINE_W-1:0]      lineDataOut;
  logic                   busDrive;
  logic                   dataStrobe;
  logic                   busy;

  int checks;
  int failures;

  main_memory_responder #(
    .MEM_LINES     (64),
    .DRAM_CLK_DIV  (DIV),
    .STROBE_CYCLES (STB)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .fetchReq     (fetchReq),
    .writebackReq (writebackReq),
    .lineAddress  (lineAddress),
    .lineDataIn   (lineDataIn),
    .lineDataOut  (lineDataOut),
    .busDrive     (busDrive),
    .dataStrobe   (dataStrobe),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives request levels and operands on a falling edge.
  task automatic applyStimulus(input logic fetch, input logic wb,
                               input logic [LINE_ADDR_W-1:0] addr, input logic [63:0] data);
    @(negedge clk);
    fetchReq     = fetch;
    writebackReq = wb;
    lineAddress  = addr;
    lineDataIn   = data;
  endtask

  // Returns cycles from the acceptance edge to the first strobe sample, or -1.
  task automatic waitStrobe(output int lat);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (dataStrobe) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic strobeWidth(output int w);
    w = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!dataStrobe) break;
      w++;
    end
  endtask

  task automatic dropAndIdle(input string tag);
    int n;
    fetchReq     = 1'b0;
    writebackReq = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_busDriveIdle"}, {63'd0, busDrive}, 64'd0);
  endtask

  task automatic doOp(input string tag, input logic fetch, input logic wb,
                      input logic [LINE_ADDR_W-1:0] addr, input logic [63:0] data,
                      input int expLat, input logic expDrive, input logic [63:0] expData);
    int lat;
    int w;
    applyStimulus(fetch, wb, addr, data);
    waitStrobe(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_busDrive"}, {63'd0, busDrive}, {63'd0, expDrive});
    if (expDrive) checkOutput({tag, "_data"}, lineDataOut, expData);
    strobeWidth(w);
    checkOutput({tag, "_strobeWidth"}, 64'(w), 64'(STB));
  endtask

  initial begin
    int lat;
    int pulses;
    logic prev;
    checks       = 0;
    failures     = 0;
    reset_L      = 1'b0;
    fetchReq     = 1'b0;
    writebackReq = 1'b0;
    lineAddress  = '0;
    lineDataIn   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_strobe", {63'd0, dataStrobe}, 64'd0);
    checkOutput("rst_busDrive", {63'd0, busDrive}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_data", lineDataOut, 64'd0);
    reset_L = 1'b1;

    doOp("wr5", 1'b0, 1'b1, 13'd5, 64'hdead_beef, WR_LAT, 1'b0, 64'd0);
    dropAndIdle("wr5");
    doOp("rd5", 1'b1, 1'b0, 13'd5, 64'd0, RD_LAT, 1'b1, 64'hdead_beef);
    dropAndIdle("rd5");

    doOp("wr8", 1'b0, 1'b1, 13'd8, 64'h0123_4567_89ab_cdef, WR_LAT, 1'b0, 64'd0);
    dropAndIdle("wr8");
    doOp("wr9", 1'b0, 1'b1, 13'd9, 64'hcafe_babe, WR_LAT, 1'b0, 64'd0);
    dropAndIdle("wr9");
    doOp("rd9", 1'b1, 1'b0, 13'd9, 64'd0, RD_LAT, 1'b1, 64'hcafe_babe);
    dropAndIdle("rd9");
    checkOutput("rd9_dataHeld", lineDataOut, 64'hcafe_babe);
    doOp("rd8", 1'b1, 1'b0, 13'd8, 64'd0, RD_LAT, 1'b1, 64'h0123_4567_89ab_cdef);
    dropAndIdle("rd8");

    // Both requests together: write-back wins, no retrigger while held.
    doOp("both", 1'b1, 1'b1, 13'd12, 64'h5555_6666_7777_8888, WR_LAT, 1'b0, 64'd0);
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dataStrobe) pulses++;
    end
    checkOutput("both_noRetrigger", 64'(pulses), 64'd0);
    checkOutput("both_busyHeld", {63'd0, busy}, 64'd1);
    dropAndIdle("both");
    doOp("rd12", 1'b1, 1'b0, 13'd12, 64'd0, RD_LAT, 1'b1, 64'h5555_6666_7777_8888);
    dropAndIdle("rd12");

    // Held fetch level over three read latencies produces a single pulse.
    applyStimulus(1'b1, 1'b0, 13'd5, 64'd0);
    pulses = 0;
    prev   = 1'b0;
    for (int k = 0; k < 3 * RD_LAT; k++) begin
      @(negedge clk);
      if (dataStrobe && !prev) pulses++;
      prev = dataStrobe;
    end
    checkOutput("held_pulses", 64'(pulses), 64'd1);
    checkOutput("held_busy", {63'd0, busy}, 64'd1);
    fetchReq = 1'b0;
    @(negedge clk);
    checkOutput("held_release", {63'd0, busy}, 64'd0);

    // Reset during WRITE_WAIT must abort without committing.
    doOp("wr3", 1'b0, 1'b1, 13'd3, 64'h1111_2222_3333_4444, WR_LAT, 1'b0, 64'd0);
    dropAndIdle("wr3");
    applyStimulus(1'b0, 1'b1, 13'd3, 64'h8bad_f00d);
    repeat (15) @(negedge clk);
    checkOutput("abort_inWait", {63'd0, busy}, 64'd1);
    reset_L      = 1'b0;
    writebackReq = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_strobe", {63'd0, dataStrobe}, 64'd0);
    checkOutput("abort_busDrive", {63'd0, busDrive}, 64'd0);
    checkOutput("abort_data", lineDataOut, 64'd0);
    pulses = 0;
    for (int k = 0; k < 2 * WR_LAT; k++) begin
      @(negedge clk);
      if (dataStrobe) pulses++;
    end
    checkOutput("abort_noStrobe", 64'(pulses), 64'd0);
    doOp("rd3", 1'b1, 1'b0, 13'd3, 64'd0, RD_LAT, 1'b1, 64'h1111_2222_3333_4444);
    dropAndIdle("rd3");

    // Index aliasing: line 70 maps onto entry 6.
    doOp("wr70", 1'b0, 1'b1, 13'd70, 64'hAAAA_AAAA_AAAA_AAAA, WR_LAT, 1'b0, 64'd0);
    dropAndIdle("wr70");
    doOp("rd6", 1'b1, 1'b0, 13'd6, 64'd0, RD_LAT, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
    dropAndIdle("rd6");

    lat = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
